// File: rtl/legal_move_checker.sv
// legal_move_checker: probes the maze tile memory at the leading-edge corners of the four
// candidate moves and reports one legal bit per direction. Optional macro: WRAP_TUNNEL_EN.
module legal_move_checker #(
    parameter int TILE_SHIFT  = 3,
    parameter int MAZE_COLS   = 28,
    parameter int MAZE_ROWS   = 36,
    parameter int SPRITE_SIZE = 8,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [9:0]        xpos,
    input  logic [9:0]        ypos,
    input  logic [7:0]        speed,
    output logic              tile_rd_en,
    output logic [ADDR_W-1:0] tile_addr,
    input  logic              tile_data,
    output logic              busy,
    output logic              done,
    output logic [3:0]        legal_moves
);
    localparam logic signed [11:0] S  = 12'(SPRITE_SIZE - 1);
    localparam logic signed [11:0] PW = 12'(MAZE_COLS << TILE_SHIFT);
    localparam logic signed [11:0] PH = 12'(MAZE_ROWS << TILE_SHIFT);

    typedef enum logic [1:0] {IDLE, PROBE, FLUSH, REPORT} state_t;
    state_t state;

    logic signed [11:0] x_p0, y_p0, sp_p0;
    logic        [2:0]  k_p0, k_p1;
    logic               rd_p1;
    logic        [7:0]  wall_p1, wall_n;

    logic signed [11:0] src_x, src_y, src_sp, px_nxt, py_nxt;
    logic        [2:0]  k_nxt;
    logic               issue, oob_nxt;
    logic [ADDR_W-1:0]  addr_nxt;

    function automatic logic signed [11:0] probe_x(input logic [2:0] k,
                                                   input logic signed [11:0] x,
                                                   input logic signed [11:0] sp);
        case (k)
            3'd0, 3'd1: probe_x = x - sp;
            3'd2, 3'd3: probe_x = x + sp + S;
            3'd4, 3'd6: probe_x = x;
            default:    probe_x = x + S;
        endcase
    endfunction

    function automatic logic signed [11:0] probe_y(input logic [2:0] k,
                                                   input logic signed [11:0] y,
                                                   input logic signed [11:0] sp);
        case (k)
            3'd0, 3'd2: probe_y = y;
            3'd1, 3'd3: probe_y = y + S;
            3'd4, 3'd5: probe_y = y - sp;
            default:    probe_y = y + sp + S;
        endcase
    endfunction

    // Tunnel wrap is a single fold; anything still outside afterwards is a wall.
    function automatic logic signed [11:0] wrap_x(input logic signed [11:0] px);
`ifdef WRAP_TUNNEL_EN
        if (px < 12'sd0)
            wrap_x = px + PW;
        else if (px >= PW)
            wrap_x = px - PW;
        else
            wrap_x = px;
`else
        wrap_x = px;
`endif
    endfunction

    function automatic logic out_of_bounds(input logic signed [11:0] px,
                                           input logic signed [11:0] py);
        out_of_bounds = (px < 12'sd0) || (px >= PW) || (py < 12'sd0) || (py >= PH);
    endfunction

    function automatic logic [ADDR_W-1:0] tile_index(input logic signed [11:0] px,
                                                     input logic signed [11:0] py);
        logic [11:0] col, row;
        col = 12'(px >>> TILE_SHIFT);
        row = 12'(py >>> TILE_SHIFT);
        tile_index = ADDR_W'(row * 12'(MAZE_COLS) + col);
    endfunction

    function automatic logic [3:0] legal_of(input logic [7:0] w);
        legal_of = {~(w[6] | w[7]), ~(w[4] | w[5]), ~(w[2] | w[3]), ~(w[0] | w[1])};
    endfunction

    // Probe 0 is formed straight from the ports so its address is registered on the start edge.
    always_comb begin
        if (state == IDLE) begin
            src_x  = $signed({2'b00, xpos});
            src_y  = $signed({2'b00, ypos});
            src_sp = $signed({4'b0000, speed});
            k_nxt  = 3'd0;
        end else begin
            src_x  = x_p0;
            src_y  = y_p0;
            src_sp = sp_p0;
            k_nxt  = k_p0 + 3'd1;
        end
        px_nxt   = wrap_x(probe_x(k_nxt, src_x, src_sp));
        py_nxt   = probe_y(k_nxt, src_y, src_sp);
        oob_nxt  = out_of_bounds(px_nxt, py_nxt);
        addr_nxt = tile_index(px_nxt, py_nxt);
        issue    = ((state == IDLE) && start) || ((state == PROBE) && (k_p0 != 3'd7));
    end

    always_comb begin
        wall_n = wall_p1;
        if (rd_p1)
            wall_n[k_p1] = tile_data;
    end

    // Stage p0: probe issue; stage p1: wall capture one cycle behind the read strobe.
    always_ff @(posedge clk) begin
        k_p1    <= k_p0;
        wall_p1 <= wall_n;
        if (issue) begin
            x_p0  <= src_x;
            y_p0  <= src_y;
            sp_p0 <= src_sp;
            k_p0  <= k_nxt;
            if (oob_nxt)
                wall_p1[k_nxt] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            tile_rd_en  <= 1'b0;
            tile_addr   <= '0;
            legal_moves <= 4'b0000;
            rd_p1       <= 1'b0;
        end else begin
            done       <= 1'b0;
            rd_p1      <= tile_rd_en;
            tile_rd_en <= issue && !oob_nxt;
            if (issue && !oob_nxt)
                tile_addr <= addr_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= PROBE;
                        busy  <= 1'b1;
                    end
                end
                PROBE: begin
                    if (k_p0 == 3'd7)
                        state <= FLUSH;
                end
                FLUSH: begin
                    legal_moves <= legal_of(wall_n);
                    done        <= 1'b1;
                    state       <= REPORT;
                end
                REPORT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_legal_move_checker.sv
// Directed bench for legal_move_checker with a 1-cycle synchronous tile ROM model.
// Honours WRAP_TUNNEL_EN for the left-edge expectations.
module tb_legal_move_checker;
    logic       clk = 1'b0;
    logic       rst, start, tile_data, tile_rd_en, busy, done;
    logic [9:0] xpos, ypos, tile_addr;
    logic [7:0] speed;
    logic [3:0] legal_moves;

    int checks = 0;
    int failures = 0;

    logic       wall_map [0:1023];
    logic [9:0] obs_addr  [1:11];
    logic       obs_rd    [1:11];
    logic       obs_done  [1:11];
    logic       obs_busy  [1:11];
    logic [3:0] obs_legal [1:11];

    legal_move_checker dut (
        .clk(clk), .rst(rst), .start(start), .xpos(xpos), .ypos(ypos), .speed(speed),
        .tile_rd_en(tile_rd_en), .tile_addr(tile_addr), .tile_data(tile_data),
        .busy(busy), .done(done), .legal_moves(legal_moves)
    );

    always #5 clk = ~clk;

    // Outside read-follow cycles the ROM returns junk (1) so ignored data is visible.
    always @(posedge clk)
        tile_data <= tile_rd_en ? wall_map[tile_addr] : 1'b1;

    task automatic clear_map();
        for (int i = 0; i < 1024; i++) wall_map[i] = 1'b0;
    endtask

    // Returns at the falling edge of cycle T+1 (start sampled at edge T).
    task automatic launch(input logic [9:0] x, input logic [9:0] y, input logic [7:0] sp);
        @(negedge clk);
        xpos = x; ypos = y; speed = sp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Records cycles T+1..T+11, starting in the current cycle.
    task automatic sample_run();
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) @(negedge clk);
            obs_addr[c] = tile_addr; obs_rd[c] = tile_rd_en; obs_done[c] = done;
            obs_busy[c] = busy; obs_legal[c] = legal_moves;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; xpos = '0; ypos = '0; speed = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || legal_moves !== 4'b0000 || tile_rd_en !== 1'b0 || tile_addr !== 10'd0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b legal=%b rd_en=%b addr=%0d, required 0 0 0000 0 0",
                     busy, done, legal_moves, tile_rd_en, tile_addr);
        end
        rst = 1'b1;
    endtask

    task automatic test_open_maze();
        logic [9:0] ea [8] = '{10'd348, 10'd376, 10'd349, 10'd377, 10'd348, 10'd349, 10'd376, 10'd377};
        clear_map();
        launch(10'd100, 10'd100, 8'd1);
        sample_run();
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (obs_rd[c] !== 1'b1 || obs_addr[c] !== ea[c-1]) begin
                failures++;
                $display("FAIL open_slot%0d: rd_en=%b addr=%0d, required rd_en=1 addr=%0d", c-1, obs_rd[c], obs_addr[c], ea[c-1]);
            end
        end
        for (int c = 1; c <= 11; c++) begin
            checks++;
            if (obs_done[c] !== (c == 10) || obs_busy[c] !== (c <= 10) || obs_legal[c] !== ((c >= 10) ? 4'b1111 : 4'b0000)) begin
                failures++;
                $display("FAIL open_cycle%0d: done=%b busy=%b legal=%b, required done=%b busy=%b legal=%b", c,
                         obs_done[c], obs_busy[c], obs_legal[c], c == 10, c <= 10, (c >= 10) ? 4'b1111 : 4'b0000);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] ea [8] = '{10'd12, 10'd12, 10'd13, 10'd13, 10'd13, 10'd13, 10'd40, 10'd41};
        logic       er [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        clear_map();
        launch(10'd100, 10'd100, 8'd1);
        repeat (9) @(negedge clk);
        checks++;
        if (done !== 1'b1 || legal_moves !== 4'b1111) begin
            failures++;
            $display("FAIL b2b_first_done: done=%b legal=%b, required 1 1111", done, legal_moves);
        end
        xpos = 10'd100; ypos = 10'd0; speed = 8'd1; start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_start_in_report: busy=%b done=%b, required 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        sample_run();
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (obs_rd[c] !== er[c-1] || obs_addr[c] !== ea[c-1]) begin
                failures++;
                $display("FAIL top_slot%0d: rd_en=%b addr=%0d, required rd_en=%b addr=%0d", c-1, obs_rd[c], obs_addr[c], er[c-1], ea[c-1]);
            end
        end
        for (int c = 1; c <= 11; c++) begin
            checks++;
            if (obs_done[c] !== (c == 10) || obs_busy[c] !== (c <= 10) || obs_legal[c] !== ((c >= 10) ? 4'b1011 : 4'b1111)) begin
                failures++;
                $display("FAIL top_cycle%0d: done=%b busy=%b legal=%b, required done=%b busy=%b legal=%b", c,
                         obs_done[c], obs_busy[c], obs_legal[c], c == 10, c <= 10, (c >= 10) ? 4'b1011 : 4'b1111);
            end
        end
    endtask

    task automatic test_wall_right();
        logic [9:0] ea [8] = '{10'd346, 10'd346, 10'd348, 10'd348, 10'd319, 10'd319, 10'd375, 10'd375};
        clear_map();
        wall_map[348] = 1'b1;
        launch(10'd88, 10'd96, 8'd1);
        sample_run();
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (obs_rd[c] !== 1'b1 || obs_addr[c] !== ea[c-1]) begin
                failures++;
                $display("FAIL wall_slot%0d: rd_en=%b addr=%0d, required rd_en=1 addr=%0d", c-1, obs_rd[c], obs_addr[c], ea[c-1]);
            end
        end
        for (int c = 1; c <= 11; c++) begin
            checks++;
            if (obs_done[c] !== (c == 10) || obs_busy[c] !== (c <= 10) || obs_legal[c] !== ((c >= 10) ? 4'b1101 : 4'b1011)) begin
                failures++;
                $display("FAIL wall_cycle%0d: done=%b busy=%b legal=%b, required done=%b busy=%b legal=%b", c,
                         obs_done[c], obs_busy[c], obs_legal[c], c == 10, c <= 10, (c >= 10) ? 4'b1101 : 4'b1011);
            end
        end
    endtask

    task automatic test_left_edge();
`ifdef WRAP_TUNNEL_EN
        logic [9:0] ea [8] = '{10'd363, 10'd363, 10'd337, 10'd337, 10'd308, 10'd308, 10'd364, 10'd364};
        logic       er [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] el = 4'b1111;
`else
        logic [9:0] ea [8] = '{10'd375, 10'd375, 10'd337, 10'd337, 10'd308, 10'd308, 10'd364, 10'd364};
        logic       er [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] el = 4'b1110;
`endif
        clear_map();
        launch(10'd0, 10'd96, 8'd2);
        sample_run();
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (obs_rd[c] !== er[c-1] || obs_addr[c] !== ea[c-1]) begin
                failures++;
                $display("FAIL left_slot%0d: rd_en=%b addr=%0d, required rd_en=%b addr=%0d", c-1, obs_rd[c], obs_addr[c], er[c-1], ea[c-1]);
            end
        end
        for (int c = 1; c <= 11; c++) begin
            checks++;
            if (obs_done[c] !== (c == 10) || obs_busy[c] !== (c <= 10) || obs_legal[c] !== ((c >= 10) ? el : 4'b1101)) begin
                failures++;
                $display("FAIL left_cycle%0d: done=%b busy=%b legal=%b, required done=%b busy=%b legal=%b", c,
                         obs_done[c], obs_busy[c], obs_legal[c], c == 10, c <= 10, (c >= 10) ? el : 4'b1101);
            end
        end
    endtask

    task automatic test_abort();
        clear_map();
        launch(10'd100, 10'd100, 8'd1);
        repeat (3) @(negedge clk);
        xpos = 10'd0; ypos = 10'd100; speed = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (tile_rd_en !== 1'b1 || tile_addr !== 10'd348 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_start_ignored: rd_en=%b addr=%0d busy=%b, required 1 348 1", tile_rd_en, tile_addr, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || legal_moves !== 4'b0000 || tile_rd_en !== 1'b0 || tile_addr !== 10'd0) begin
            failures++;
            $display("FAIL abort_reset: busy=%b done=%b legal=%b rd_en=%b addr=%0d, required 0 0 0000 0 0",
                     busy, done, legal_moves, tile_rd_en, tile_addr);
        end
        for (int c = 8; c <= 12; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_done_T+%0d: done=%b busy=%b, required 0 0", c, done, busy);
            end
        end
        wall_map[348] = 1'b1;
        launch(10'd88, 10'd96, 8'd1);
        sample_run();
        for (int c = 1; c <= 11; c++) begin
            checks++;
            if (obs_done[c] !== (c == 10) || obs_busy[c] !== (c <= 10) || obs_legal[c] !== ((c >= 10) ? 4'b1101 : 4'b0000)) begin
                failures++;
                $display("FAIL abort_fresh_cycle%0d: done=%b busy=%b legal=%b, required done=%b busy=%b legal=%b", c,
                         obs_done[c], obs_busy[c], obs_legal[c], c == 10, c <= 10, (c >= 10) ? 4'b1101 : 4'b0000);
            end
        end
    endtask

    initial begin
        clear_map();
        test_reset();
        test_open_maze();
        test_back_to_back();
        test_wall_right();
        test_left_edge();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
